// File: rtl/adc_spi_reader_pkg.sv
// Shared types and constants for the AD7476-style serial ADC reader.
// conv_cycles() gives the cycles from tick to the valid strobe, inclusive of the tick cycle.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } adc_state_e;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 4;
    localparam int DATA_BITS  = 12;

    // 1 tick cycle + SETUP half period + 2*FRAME_BITS shift half periods.
    function automatic int conv_cycles(input int sclk_div);
        return 1 + (2 * FRAME_BITS + 1) * sclk_div;
    endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// Serial ADC bus: chip select and serial clock from the reader, data back from the converter.
interface adc_spi_reader_if;

    logic adc_cs_n_o;
    logic adc_sclk_o;
    logic adc_sdo_i;

    modport master (
        output adc_cs_n_o,
        output adc_sclk_o,
        input  adc_sdo_i
    );

    modport slave (
        input  adc_cs_n_o,
        input  adc_sclk_o,
        output adc_sdo_i
    );

endinterface

// File: rtl/sample_rate_tick.sv
// Free-running sample-period divider: one-cycle tick every CLK_FREQ/SAMP_RATE cycles while enabled.
// Holding en_i low parks the counter at 0, so the first tick after enabling is a full period away.
module sample_rate_tick #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SAMP_RATE = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int PERIOD = CLK_FREQ / SAMP_RATE;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    generate
        if ((CLK_FREQ % SAMP_RATE) != 0 || PERIOD < 1) begin : g_bad_rate
            $fatal(1, "sample_rate_tick: CLK_FREQ must be an exact multiple of SAMP_RATE");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_o = en_i && cnt_last;

endmodule

// File: rtl/adc_spi_reader.sv
// AD7476-style ADC capture: one 16-bit CPOL=1 frame per sample tick, 12-bit result with valid strobe.
// Every output is a flop; the tick only steers the FSM.
module adc_spi_reader
    import adc_spi_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SAMP_RATE = 1_000_000,
    parameter int SCLK_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    adc_spi_reader_if.master      spi,
    output logic [DATA_BITS-1:0]  sample_o,
    output logic                  sample_valid_o,
    output logic                  frame_err_o
);

    localparam int PERIOD = CLK_FREQ / SAMP_RATE;
    localparam int HW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW     = $clog2(FRAME_BITS);

    // A conversion plus one SCLK half period of CS quiet time must fit inside a sample period.
    generate
        if (SCLK_DIV < 1 || conv_cycles(SCLK_DIV) + SCLK_DIV > PERIOD) begin : g_bad_timing
            $fatal(1, "adc_spi_reader: conversion does not fit in the sample period");
        end
    endgenerate

    logic tick;

    sample_rate_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .SAMP_RATE (SAMP_RATE)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .tick_o (tick)
    );

    adc_state_e              state;
    logic [HW-1:0]           half_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [FRAME_BITS-1:0]   shift;
    logic                    half_last;

    assign half_last = (half_cnt == HW'(SCLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            spi.adc_cs_n_o <= 1'b1;
            spi.adc_sclk_o <= 1'b1;
            half_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            frame_err_o    <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            frame_err_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state          <= ST_SETUP;
                        spi.adc_cs_n_o <= 1'b0;
                        half_cnt       <= '0;
                        bit_cnt        <= '0;
                    end
                end
                ST_SETUP: begin
                    if (half_last) begin
                        state          <= ST_SHIFT;
                        spi.adc_sclk_o <= 1'b0;
                        half_cnt       <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!half_last) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else if (!spi.adc_sclk_o) begin
                        // Sample at the end of the low phase: SDO settled after the falling edge.
                        half_cnt       <= '0;
                        spi.adc_sclk_o <= 1'b1;
                        shift          <= {shift[FRAME_BITS-2:0], spi.adc_sdo_i};
                    end else if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                        half_cnt       <= '0;
                        state          <= ST_DONE;
                        spi.adc_cs_n_o <= 1'b1;
                        sample_o       <= shift[DATA_BITS-1:0];
                        sample_valid_o <= 1'b1;
                        frame_err_o    <= |shift[FRAME_BITS-1:DATA_BITS];
                    end else begin
                        half_cnt       <= '0;
                        bit_cnt        <= bit_cnt + 1'b1;
                        spi.adc_sclk_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
